// File: rtl/axil_regbank_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_regbank_slave_if
// Brief    : AXI4-Lite five-channel bundle with master/slave views.
// Revision : 1.0
// ============================================================================
interface axil_regbank_slave_if #(
   parameter int ADDR_W = 32
);
   logic              AWVALID;
   logic              AWREADY;
   logic [ADDR_W-1:0] AWADDR;
   logic [2:0]        AWPROT;
   logic              WVALID;
   logic              WREADY;
   logic [31:0]       WDATA;
   logic [3:0]        WSTRB;
   logic              BVALID;
   logic              BREADY;
   logic [1:0]        BRESP;
   logic              ARVALID;
   logic              ARREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic [2:0]        ARPROT;
   logic              RVALID;
   logic              RREADY;
   logic [31:0]       RDATA;
   logic [1:0]        RRESP;

   modport master (
      output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
             ARVALID, ARADDR, ARPROT, RREADY,
      input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );

   modport slave (
      input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
             ARVALID, ARADDR, ARPROT, RREADY,
      output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );
endinterface
`default_nettype wire

// File: rtl/axil_regbank_slave.sv
`default_nettype none
// ============================================================================
// Module   : axil_regbank_slave
// Brief    : AXI4-Lite responder exposing NUM_REGS 32-bit registers.
// Revision : 1.0
// ============================================================================
module axil_regbank_slave #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8
) (
   input  wire logic                     ACLK,
   input  wire logic                     ARESET,
   axil_regbank_slave_if.slave           s_axil,
   output logic [NUM_REGS*DATA_W-1:0]    regs_o
);
   localparam int         c_IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int         c_LANES  = DATA_W / 8;
   localparam logic [1:0] c_OKAY   = 2'b00;
   localparam logic [1:0] c_SLVERR = 2'b10;

   typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   wstate_t           r_wstate;
   logic              r_awready, r_wready, r_bvalid;
   logic [1:0]        r_bresp;
   logic              r_aw_got, r_w_got;
   logic [ADDR_W-1:0] r_awaddr;
   logic [DATA_W-1:0] r_wdata;
   logic [c_LANES-1:0] r_wstrb;

   rstate_t           r_rstate;
   logic              r_arready, r_rvalid;
   logic [1:0]        r_rresp;
   logic [DATA_W-1:0] r_rdata;

   logic              w_aw_fire, w_w_fire, w_have_aw, w_have_w;
   logic [ADDR_W-1:0] w_awaddr;
   logic [DATA_W-1:0] w_wdata;
   logic [c_LANES-1:0] w_wstrb;
   logic              w_wr_ok, w_rd_ok;
   logic [c_IDX_W-1:0] w_wr_idx, w_rd_idx;
   logic              w_unused;

   // A beat arriving this cycle is used directly so the pair completes at its own edge.
   assign w_aw_fire = s_axil.AWVALID & r_awready;
   assign w_w_fire  = s_axil.WVALID  & r_wready;
   assign w_have_aw = r_aw_got | w_aw_fire;
   assign w_have_w  = r_w_got  | w_w_fire;
   assign w_awaddr  = r_aw_got ? r_awaddr : s_axil.AWADDR;
   assign w_wdata   = r_w_got  ? r_wdata  : s_axil.WDATA;
   assign w_wstrb   = r_w_got  ? r_wstrb  : s_axil.WSTRB;

   assign w_wr_idx  = w_awaddr[2 +: c_IDX_W];
   assign w_rd_idx  = s_axil.ARADDR[2 +: c_IDX_W];
   assign w_wr_ok   = ((w_awaddr      >> (2 + c_IDX_W)) == '0);
   assign w_rd_ok   = ((s_axil.ARADDR >> (2 + c_IDX_W)) == '0);

   assign w_unused  = ^{s_axil.AWPROT, s_axil.ARPROT};

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b1;
         r_wready  <= 1'b1;
         r_bvalid  <= 1'b0;
         r_bresp   <= c_OKAY;
         r_aw_got  <= 1'b0;
         r_w_got   <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_fire) begin
                  r_awaddr  <= s_axil.AWADDR;
                  r_aw_got  <= 1'b1;
                  r_awready <= 1'b0;
               end
               if (w_w_fire) begin
                  r_wdata  <= s_axil.WDATA;
                  r_wstrb  <= s_axil.WSTRB;
                  r_w_got  <= 1'b1;
                  r_wready <= 1'b0;
               end
               if (w_have_aw && w_have_w) begin
                  if (w_wr_ok) begin
                     for (int b = 0; b < c_LANES; b++)
                        if (w_wstrb[b]) r_regs[w_wr_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                  end
                  r_bresp   <= w_wr_ok ? c_OKAY : c_SLVERR;
                  r_bvalid  <= 1'b1;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_wstate  <= W_RESP;
               end
            end
            W_RESP: begin
               if (s_axil.BREADY) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_aw_got  <= 1'b0;
                  r_w_got   <= 1'b0;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // Reads sample r_regs before any same-edge commit lands, so they see the old value.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b1;
         r_rvalid  <= 1'b0;
         r_rresp   <= c_OKAY;
         r_rdata   <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (s_axil.ARVALID) begin
                  r_rdata   <= w_rd_ok ? r_regs[w_rd_idx] : '0;
                  r_rresp   <= w_rd_ok ? c_OKAY : c_SLVERR;
                  r_rvalid  <= 1'b1;
                  r_arready <= 1'b0;
                  r_rstate  <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axil.RREADY) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rstate  <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign s_axil.AWREADY = r_awready;
   assign s_axil.WREADY  = r_wready;
   assign s_axil.BVALID  = r_bvalid;
   assign s_axil.BRESP   = r_bresp;
   assign s_axil.ARREADY = r_arready;
   assign s_axil.RVALID  = r_rvalid;
   assign s_axil.RDATA   = r_rdata;
   assign s_axil.RRESP   = r_rresp;

   generate
      for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
         assign regs_o[DATA_W*k +: DATA_W] = r_regs[k];
      end
   endgenerate
endmodule
`default_nettype wire
